// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned 32-bit word accesses.
// Sub-word stores use read-modify-write; sub-word loads are lane-extracted and extended.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_merged;
  logic [3:0]  w_lane_en;

  assign w_req_err = (req_op[1:0] == 2'b11)
                   | ((req_op[1:0] == 2'b01) & req_addr[0])
                   | ((req_op[1:0] == 2'b10) & (|req_addr[1:0]));

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)
            w_state_next = S_RESP;
          else if (!req_we || req_op[1:0] != 2'b10)
            w_state_next = S_READ;
          else
            w_state_next = S_WRITE;
        end
      end
      S_READ: begin
        mem_read     = 1'b1;
        w_state_next = r_we ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_write    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_word  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_err   <= w_req_err;
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_READ)
        r_word <= mem_rdata;
    end
  end

  // Load path: lane select from the captured word, then sign/zero extend.
  always_comb begin
    w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
    case (r_op[1:0])
      2'b00:   w_load = r_op[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = r_word;
    endcase
  end

  // Store path: replicate store data across lanes, then enable only the target lanes.
  always_comb begin
    case (r_op[1:0])
      2'b00:   w_wdata_rep = {4{r_wdata[7:0]}};
      2'b01:   w_wdata_rep = {2{r_wdata[15:0]}};
      default: w_wdata_rep = r_wdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_en[gi] = (r_op[1:0] == 2'b10)
                           | ((r_op[1:0] == 2'b00) & (r_addr[1:0] == 2'(gi)))
                           | ((r_op[1:0] == 2'b01) & (r_addr[1] == 1'(gi >> 1)));
      assign w_merged[gi*8 +: 8] = w_lane_en[gi] ? w_wdata_rep[gi*8 +: 8] : r_word[gi*8 +: 8];
    end
  endgenerate

  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = mem_write ? w_merged : 32'd0;
  assign resp_err   = (r_state == S_RESP) & r_err;
  assign resp_rdata = (r_state == S_RESP && !r_we && !r_err) ? w_load : 32'd0;

endmodule
